// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types: round count, key width, round-key index and controller states.
package aes_pkg;
    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef logic [127:0] aes_key_t;
    typedef logic [3:0]   aes_rnd_t;

    typedef enum logic [1:0] {
        IDLE,
        STEP_HI,
        STEP_LO,
        DONE
    } ks_state_e;
endpackage

// File: rtl/aes_rk_regfile.sv
// (NR+1) x KEY_W round-key store: one write port, one read port with one cycle of latency.
// Out-of-range or unqualified reads return zero; rd_key holds while rd_en is low.
module aes_rk_regfile
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [3:0]       i_waddr,
    input  logic [KEY_W-1:0] i_wdata,
    input  logic             i_rd_en,
    input  logic [3:0]       i_rd_idx,
    input  logic             i_rd_ok,
    output logic             o_rd_valid,
    output logic [KEY_W-1:0] o_rd_key
);
    logic [KEY_W-1:0] r_mem [0:NR];
    logic             r_rd_valid;
    logic [KEY_W-1:0] r_rd_key;

    // Storage is deliberately unreset; i_rd_ok (keys_valid) qualifies it.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_key   <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_key <= (i_rd_ok && (i_rd_idx <= aes_rnd_t'(NR))) ? r_mem[i_rd_idx] : '0;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_key   = r_rd_key;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Drives the AES-128 expansion unit one round key per kx_ready pulse, captures keys 0..NR and checks their indices.
// Accept-to-keys_valid is 2*(NR+1) cycles; key_ready stays low while a schedule runs, so the key source holds.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_valid,
    output logic             o_key_ready,
    input  logic [KEY_W-1:0] i_key_in,
    output logic             o_kx_ready,
    output logic [KEY_W-1:0] o_kx_key,
    input  logic [3:0]       i_kx_index,
    input  logic [KEY_W-1:0] i_kx_round_key,
    output logic             o_keys_valid,
    output logic             o_kx_err,
    input  logic             i_rd_en,
    input  logic [3:0]       i_rd_idx,
    output logic             o_rd_valid,
    output logic [KEY_W-1:0] o_rd_key
);
    localparam aes_rnd_t LAST = aes_rnd_t'(NR);

    ks_state_e        r_state;
    ks_state_e        w_state_nxt;
    aes_rnd_t         r_cnt;
    logic             r_kx_ready;
    logic             r_keys_valid;
    logic             r_kx_err;
    logic [KEY_W-1:0] r_kx_key;
    logic             w_accept;
    logic             w_we;
    logic             w_idx_bad;
    logic             w_kx_err_nxt;

    // key_ready is gated by rst_n so no key can slip in during the reset cycle.
    always_comb begin
        w_state_nxt = r_state;
        o_key_ready = 1'b0;
        w_accept    = 1'b0;
        w_we        = 1'b0;
        w_idx_bad   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                o_key_ready = i_rst_n;
                if (i_key_valid && i_rst_n) begin
                    w_accept    = 1'b1;
                    w_state_nxt = STEP_HI;
                end
            end
            STEP_HI: begin
                w_we        = 1'b1;
                w_idx_bad   = (i_kx_index != r_cnt);
                w_state_nxt = STEP_LO;
            end
            STEP_LO: begin
                w_state_nxt = (r_cnt == LAST) ? DONE : STEP_HI;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_kx_err_nxt = r_kx_err | w_idx_bad;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_kx_ready   <= 1'b0;
            r_keys_valid <= 1'b0;
            r_kx_err     <= 1'b0;
            r_kx_key     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_kx_ready <= (w_state_nxt == STEP_HI);
            r_kx_err   <= w_kx_err_nxt;
            if (w_accept) begin
                r_kx_key     <= i_key_in;
                r_cnt        <= '0;
                r_keys_valid <= 1'b0;
                r_kx_err     <= 1'b0;
            end
            if (r_state == STEP_LO) begin
                if (r_cnt == LAST) begin
                    r_keys_valid <= ~w_kx_err_nxt;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    aes_rk_regfile #(
        .NR    (NR),
        .KEY_W (KEY_W)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_we       (w_we),
        .i_waddr    (r_cnt),
        .i_wdata    (i_kx_round_key),
        .i_rd_en    (i_rd_en),
        .i_rd_idx   (i_rd_idx),
        .i_rd_ok    (r_keys_valid),
        .o_rd_valid (o_rd_valid),
        .o_rd_key   (o_rd_key)
    );

    assign o_kx_ready   = r_kx_ready;
    assign o_kx_key     = r_kx_key;
    assign o_keys_valid = r_keys_valid;
    assign o_kx_err     = r_kx_err;
endmodule
